// File: rtl/gfx_pkg.sv
// Shared types and defaults for the draw unit's pixel write path.
// Holds the writer FSM encoding and the queued pixel record width.
package gfx_pkg;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int COORD_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_WRITE = 2'd2
  } wr_state_e;

  // Queued record is {x, y, colour}
  function automatic int pix_w(input int color_w);
    return 2 * COORD_W + color_w;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO buffering pixel records ahead of the writer FSM.
// A pop frees the slot used by a simultaneous push when full.
module pixel_fifo
  import gfx_pkg::*;
#(
  parameter int WIDTH = pix_w(8),
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_writer.sv
// Buffers drawn pixels and writes them to the framebuffer at Y*H_RES+X.
// Define PIXEL_CLIP_EN to drop and count off-screen pixels at the input.
module pixel_writer
  import gfx_pkg::*;
#(
  parameter int H_RES   = H_RES_DEF,
  parameter int V_RES   = V_RES_DEF,
  parameter int ADDR_W  = 16,
  parameter int COLOR_W = 8,
  parameter int DEPTH   = 8
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               PIX_VALID,
  input  logic [7:0]         X_IN,
  input  logic [7:0]         Y_IN,
  input  logic [COLOR_W-1:0] COLOR,
  output logic               PIX_READY,
  input  logic               DRAW_DONE,
  output logic [ADDR_W-1:0]  MEM_ADDR,
  output logic [COLOR_W-1:0] MEM_DATA,
  output logic               MEM_WE,
  input  logic               MEM_GNT,
  output logic               FLUSHED,
  output logic               BUSY,
  output logic [7:0]         CLIP_CNT
);

  localparam int PW = pix_w(COLOR_W);

  wr_state_e          state_q, state_d;
  logic [PW-1:0]      pix_q, pix_d;
  logic [PW-1:0]      fifo_rdata;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               done_pend_q, done_pend_d;
  logic               fifo_full, fifo_empty;
  logic               fifo_push, fifo_pop;
  logic               accept, drop, flush;
  logic [7:0]         px, py;

  assign PIX_READY = ~fifo_full;
  assign accept    = PIX_VALID & PIX_READY;
  assign fifo_push = accept & ~drop;

`ifdef PIXEL_CLIP_EN
  logic [7:0] clip_q, clip_d;
  logic       oob;

  assign oob  = (int'(X_IN) >= H_RES) | (int'(Y_IN) >= V_RES);
  assign drop = accept & oob;

  always_comb begin
    clip_d = clip_q;
    if (drop && clip_q != 8'hFF) clip_d = clip_q + 8'd1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) clip_q <= '0;
    else        clip_q <= clip_d;
  end

  assign CLIP_CNT = clip_q;
`else
  logic unused_vres;

  assign unused_vres = (V_RES > 0);
  assign drop        = 1'b0;
  assign CLIP_CNT    = '0;
`endif

  pixel_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push_i  (fifo_push),
    .wdata_i ({X_IN, Y_IN, COLOR}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: state_d = S_WRITE;
      S_WRITE: begin
        if (MEM_GNT) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = S_ADDR;
          end else begin
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    MEM_WE = (state_q == S_WRITE);
    BUSY   = ~fifo_empty | (state_q != S_IDLE);
  end

  assign px = pix_q[PW-1 -: 8];
  assign py = pix_q[PW-9 -: 8];

  // Modular arithmetic in ADDR_W bits equals the truncated full product
  always_comb begin
    pix_d  = fifo_pop ? fifo_rdata : pix_q;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == S_ADDR) begin
      addr_d = ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
      data_d = pix_q[COLOR_W-1:0];
    end
  end

  assign flush       = done_pend_q & fifo_empty & (state_q == S_IDLE);
  assign done_pend_d = DRAW_DONE | (done_pend_q & ~flush);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      pix_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      done_pend_q <= 1'b0;
    end else begin
      pix_q       <= pix_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      done_pend_q <= done_pend_d;
    end
  end

  assign MEM_ADDR = addr_q;
  assign MEM_DATA = data_q;
  assign FLUSHED  = flush;

endmodule

// File: tb/tb_pixel_writer.sv
// Directed bench for pixel_writer: latency, stall, backpressure,
// flush pulse, mid-write reset and the clip configuration.
module tb_pixel_writer;

  localparam int AW = 16;
  localparam int CW = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          pix_valid = 1'b0;
  logic [7:0]    x_in = '0;
  logic [7:0]    y_in = '0;
  logic [CW-1:0] color = '0;
  logic          draw_done = 1'b0;
  logic          mem_gnt = 1'b0;
  logic          pix_ready;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_data;
  logic          mem_we;
  logic          flushed;
  logic          busy;
  logic [7:0]    clip_cnt;

  int total = 0;
  int bad = 0;
  logic [AW+CW-1:0] wr_log[$];

  pixel_writer dut (
    .ACLK      (aclk),
    .ARESET    (areset),
    .PIX_VALID (pix_valid),
    .X_IN      (x_in),
    .Y_IN      (y_in),
    .COLOR     (color),
    .PIX_READY (pix_ready),
    .DRAW_DONE (draw_done),
    .MEM_ADDR  (mem_addr),
    .MEM_DATA  (mem_data),
    .MEM_WE    (mem_we),
    .MEM_GNT   (mem_gnt),
    .FLUSHED   (flushed),
    .BUSY      (busy),
    .CLIP_CNT  (clip_cnt)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk)
    if (!areset && mem_we === 1'b1 && mem_gnt === 1'b1)
      wr_log.push_back({mem_addr, mem_data});

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  // Call #1 after a rising edge; returns #1 after the accepting edge
  task automatic push_pix(input logic [7:0] x, input logic [7:0] y,
                          input logic [7:0] c, input logic done);
    int n;
    pix_valid = 1'b1;
    x_in = x;
    y_in = y;
    color = c;
    draw_done = done;
    n = 0;
    forever begin
      @(posedge aclk);
      if (pix_ready) break;
      n++;
      if (n > 50) begin
        total++;
        bad++;
        $display("FAIL push_timeout got=stalled want=accepted");
        break;
      end
    end
    #1;
    pix_valid = 1'b0;
    draw_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge aclk);
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL rst_we got=%b want=0", mem_we);
    end
    total++;
    if (mem_addr !== 16'd0) begin
      bad++; $display("FAIL rst_addr got=%0d want=0", mem_addr);
    end
    total++;
    if (mem_data !== 8'd0) begin
      bad++; $display("FAIL rst_data got=%0h want=0", mem_data);
    end
    total++;
    if (flushed !== 1'b0) begin
      bad++; $display("FAIL rst_flushed got=%b want=0", flushed);
    end
    total++;
    if (clip_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_clip got=%0d want=0", clip_cnt);
    end
    total++;
    if (pix_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b want=1", pix_ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_latency();
    int s;
    @(posedge aclk); #1;
    mem_gnt = 1'b1;
    s = wr_log.size();
    push_pix(8'd3, 8'd2, 8'h5A, 1'b0);
    @(negedge aclk);
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL lat_we_c1 got=%b want=0", mem_we);
    end
    @(negedge aclk);
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL lat_we_c2 got=%b want=0", mem_we);
    end
    @(negedge aclk);
    total++;
    if ({mem_we, mem_addr, mem_data} !== {1'b1, 16'd323, 8'h5A}) begin
      bad++;
      $display("FAIL lat_write got=%b/%0d/%0h want=1/323/5a",
               mem_we, mem_addr, mem_data);
    end
    @(negedge aclk);
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL lat_we_drop got=%b want=0", mem_we);
    end
    repeat (5) @(negedge aclk);
    total++;
    if (wr_log.size() - s !== 1) begin
      bad++; $display("FAIL lat_count got=%0d want=1", wr_log.size() - s);
    end
  endtask

  task automatic test_stall();
    int s;
    bit seen;
    @(posedge aclk); #1;
    mem_gnt = 1'b0;
    s = wr_log.size();
    push_pix(8'd10, 8'd4, 8'h33, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge aclk);
      if (mem_we === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL stall_we_timeout got=0 want=1");
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({mem_we, mem_addr, mem_data} !== {1'b1, 16'd650, 8'h33}) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b/%0d/%0h want=1/650/33",
                 i, mem_we, mem_addr, mem_data);
      end
      @(negedge aclk);
    end
    mem_gnt = 1'b1;
    total++;
    if (mem_we !== 1'b1) begin
      bad++; $display("FAIL stall_gnt_cycle got=%b want=1", mem_we);
    end
    @(posedge aclk); #1;
    mem_gnt = 1'b0;
    @(negedge aclk);
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL stall_drop got=%b want=0", mem_we);
    end
    total++;
    if (wr_log.size() - s !== 1) begin
      bad++; $display("FAIL stall_count got=%0d want=1", wr_log.size() - s);
    end
  endtask

  task automatic test_backpressure();
    int s;
    int acc;
    logic rdy;
    logic [AW+CW-1:0] exp;
    @(posedge aclk); #1;
    mem_gnt = 1'b0;
    s = wr_log.size();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      x_in = 8'(3 * i + 1);
      y_in = 8'(i + 1);
      color = 8'(8'h80 + i);
      @(posedge aclk);
      rdy = pix_ready;
      #1;
      if (!rdy) break;
      acc++;
    end
    total++;
    if (acc !== 9) begin
      bad++; $display("FAIL bp_accepted got=%0d want=9", acc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      total++;
      if (pix_ready !== 1'b0) begin
        bad++; $display("FAIL bp_ready%0d got=%b want=0", i, pix_ready);
      end
    end
    @(posedge aclk); #1;
    pix_valid = 1'b0;
    mem_gnt = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge aclk);
      if (wr_log.size() - s >= 9) break;
    end
    repeat (6) @(negedge aclk);
    total++;
    if (wr_log.size() - s !== 9) begin
      bad++; $display("FAIL bp_count got=%0d want=9", wr_log.size() - s);
    end
    for (int i = 0; i < 9; i++) begin
      exp = {16'((i + 1) * 160 + 3 * i + 1), 8'(8'h80 + i)};
      total++;
      if (wr_log.size() <= s + i) begin
        bad++; $display("FAIL bp_write%0d got=missing want=%h", i, exp);
      end else if (wr_log[s + i] !== exp) begin
        bad++;
        $display("FAIL bp_write%0d got=%h want=%h", i, wr_log[s + i], exp);
      end
    end
  endtask

  task automatic test_flush();
    int s;
    int last_gnt;
    int flush_k;
    int flush_n;
    logic busy_at;
    @(posedge aclk); #1;
    mem_gnt = 1'b1;
    s = wr_log.size();
    push_pix(8'd0, 8'd0, 8'h11, 1'b0);
    push_pix(8'd1, 8'd0, 8'h22, 1'b0);
    push_pix(8'd2, 8'd0, 8'h33, 1'b0);
    push_pix(8'd3, 8'd0, 8'h44, 1'b1);
    last_gnt = -100;
    flush_k = -1;
    flush_n = 0;
    busy_at = 1'bx;
    for (int k = 0; k < 30; k++) begin
      @(negedge aclk);
      if (mem_we === 1'b1 && mem_gnt === 1'b1) last_gnt = k;
      if (flushed === 1'b1) begin
        flush_n++;
        flush_k = k;
        busy_at = busy;
      end
    end
    total++;
    if (flush_n !== 1) begin
      bad++; $display("FAIL flush_pulses got=%0d want=1", flush_n);
    end
    total++;
    if (flush_k !== last_gnt + 1) begin
      bad++;
      $display("FAIL flush_timing got=%0d want=%0d", flush_k, last_gnt + 1);
    end
    total++;
    if (busy_at !== 1'b0) begin
      bad++; $display("FAIL flush_busy got=%b want=0", busy_at);
    end
    total++;
    if (wr_log.size() - s !== 4) begin
      bad++; $display("FAIL flush_writes got=%0d want=4", wr_log.size() - s);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    bit seen;
    bit we_seen;
    @(posedge aclk); #1;
    mem_gnt = 1'b0;
    push_pix(8'd5, 8'd5, 8'h01, 1'b0);
    push_pix(8'd6, 8'd5, 8'h02, 1'b0);
    push_pix(8'd7, 8'd5, 8'h03, 1'b0);
    push_pix(8'd8, 8'd5, 8'h04, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge aclk);
      if (mem_we === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL rmid_we_timeout got=0 want=1");
    end
    s = wr_log.size();
    areset = 1'b1;
    #1;
    total++;
    if (mem_we !== 1'b0) begin
      bad++; $display("FAIL rmid_we got=%b want=0", mem_we);
    end
    total++;
    if (pix_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_ready got=%b want=1", pix_ready);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL rmid_busy got=%b want=0", busy);
    end
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    mem_gnt = 1'b1;
    we_seen = 1'b0;
    repeat (10) begin
      @(negedge aclk);
      if (mem_we !== 1'b0) we_seen = 1'b1;
    end
    total++;
    if (we_seen) begin
      bad++; $display("FAIL rmid_after_we got=1 want=0");
    end
    total++;
    if (wr_log.size() - s !== 0) begin
      bad++; $display("FAIL rmid_writes got=%0d want=0", wr_log.size() - s);
    end
  endtask

  task automatic test_clip();
    int s;
    @(posedge aclk); #1;
    mem_gnt = 1'b1;
    s = wr_log.size();
`ifdef PIXEL_CLIP_EN
    push_pix(8'd200, 8'd5, 8'h77, 1'b0);
    push_pix(8'd10, 8'd130, 8'h78, 1'b0);
    repeat (8) @(negedge aclk);
    total++;
    if (wr_log.size() - s !== 0) begin
      bad++; $display("FAIL clip_writes got=%0d want=0", wr_log.size() - s);
    end
    total++;
    if (clip_cnt !== 8'd2) begin
      bad++; $display("FAIL clip_cnt got=%0d want=2", clip_cnt);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL clip_busy got=%b want=0", busy);
    end
`else
    push_pix(8'd200, 8'd5, 8'h77, 1'b0);
    repeat (8) @(negedge aclk);
    total++;
    if (wr_log.size() - s !== 1) begin
      bad++; $display("FAIL noclip_writes got=%0d want=1", wr_log.size() - s);
    end else begin
      total++;
      if (wr_log[s] !== {16'd1000, 8'h77}) begin
        bad++; $display("FAIL noclip_addr got=%h want=%h", wr_log[s],
                        {16'd1000, 8'h77});
      end
    end
    total++;
    if (clip_cnt !== 8'd0) begin
      bad++; $display("FAIL noclip_cnt got=%0d want=0", clip_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stall();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_clip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
